// File: rtl/mem_port_pkg.sv
// mem_port_pkg: shared definitions for the memory port controller.
//   - access size encodings
//   - controller state enum
//   - alignment check used when a request is accepted
package mem_port_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // A request is rejected when its size is illegal or its address is not
  // naturally aligned to the access size.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] off);
    logic bad;
    case (size)
      SZ_WORD: bad = (off != 2'b00);
      SZ_HALF: bad = off[0];
      SZ_BYTE: bad = 1'b0;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// byte_lane_merge: combinational little-endian lane handling.
//   size     in  2   access size (mem_port_pkg encodings)
//   off      in  2   byte offset within the word (addr[1:0])
//   old_word in  32  word as read from memory
//   new_data in  32  right-aligned store data
//   merged   out 32  old_word with the selected lane replaced by new_data
//   lane     out 32  selected lane of old_word, zero-extended, right-aligned
module byte_lane_merge
  import mem_port_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  output logic [31:0] merged,
  output logic [31:0] lane
);

  logic [4:0] bit_ofs;

  // Lane k starts at bit 8k; halfwords only ever sit at offset 0 or 2.
  assign bit_ofs = {off, 3'b000};

  always_comb begin
    merged = old_word;
    lane   = 32'h0;
    case (size)
      SZ_BYTE: begin
        merged[bit_ofs +: 8] = new_data[7:0];
        lane[7:0]            = old_word[bit_ofs +: 8];
      end
      SZ_HALF: begin
        merged[{off[1], 4'b0000} +: 16] = new_data[15:0];
        lane[15:0]                      = old_word[{off[1], 4'b0000} +: 16];
      end
      default: begin
        merged = new_data;
        lane   = old_word;
      end
    endcase
  end

endmodule

// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl: req/done responder between the CPU datapath and the
// synchronous word-wide memory. Handles read wait states and performs
// read-modify-write for byte and halfword stores.
//   clk, reset        clock (rising edge) and async active-low reset
//   req/wr/size/addr  request, sampled only in IDLE
//   wdata             right-aligned store data
//   rdata             zero-extended load result, held until the next load
//   busy/done         busy outside IDLE; one-cycle completion pulse
//   misalign          valid with done; request rejected, no memory access
//   mem_addr/mem_wr/mem_wdata/mem_rdata  memory side
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for req; latches request and checks alignment
// ST_RD   | read wait states; captures mem_rdata on the last one
// ST_WR   | one-cycle write strobe to memory
// ST_DONE | done pulse, then back to IDLE unconditionally
module mem_port_ctrl
  import mem_port_pkg::*;
#(
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        misalign,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LAT - 1);
  localparam logic [CW-1:0] CNT_SAT  = CW'(MEM_LAT);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          wr_q;
  logic [1:0]    size_q;
  logic [1:0]    off_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          busy_q;
  logic          done_q;
  logic          misalign_q;
  logic [31:0]   mem_addr_q;
  logic          mem_wr_q;
  logic [31:0]   mem_wdata_q;

  logic [31:0]   merged_d;
  logic [31:0]   lane_d;

  // Lanes are taken straight from mem_rdata on the capture cycle; for a
  // sub-word store the captured word is held, already merged, in mem_wdata_q.
  byte_lane_merge u_lane (
    .size     (size_q),
    .off      (off_q),
    .old_word (mem_rdata),
    .new_data (wdata_q),
    .merged   (merged_d),
    .lane     (lane_d)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      size_q      <= SZ_WORD;
      off_q       <= 2'b00;
      wdata_q     <= 32'h0;
      rdata_q     <= 32'h0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      misalign_q  <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wr_q    <= 1'b0;
      mem_wdata_q <= 32'h0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            wr_q       <= wr;
            size_q     <= size;
            off_q      <= addr[1:0];
            wdata_q    <= wdata;
            mem_addr_q <= {addr[31:2], 2'b00};
            busy_q     <= 1'b1;
            if (is_misaligned(size, addr[1:0])) begin
              misalign_q <= 1'b1;
              done_q     <= 1'b1;
              state_q    <= ST_DONE;
            end else if (wr && (size == SZ_WORD)) begin
              mem_wdata_q <= wdata;
              mem_wr_q    <= 1'b1;
              state_q     <= ST_WR;
            end else begin
              cnt_q   <= '0;
              state_q <= ST_RD;
            end
          end
        end

        ST_RD: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q <= CNT_SAT;
            if (wr_q) begin
              mem_wdata_q <= merged_d;
              mem_wr_q    <= 1'b1;
              state_q     <= ST_WR;
            end else begin
              rdata_q <= lane_d;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end
          end else if (cnt_q != CNT_SAT) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_WR: begin
          mem_wr_q <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= ST_DONE;
        end

        ST_DONE: begin
          done_q     <= 1'b0;
          misalign_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign misalign  = misalign_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wr    = mem_wr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Bench for mem_port_ctrl with MEM_LAT = 2 and a small word memory model.
module tb_mem_port_ctrl;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        busy;
  logic        done;
  logic        misalign;
  logic [31:0] mem_addr;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  // memory model: one registered read stage gives LAT=2 from address to data
  logic [31:0] mem [64];
  logic [31:0] rd_pipe = 32'h0;
  logic        tb_we = 1'b0;
  logic [5:0]  tb_idx = 6'd0;
  logic [31:0] tb_dat = 32'h0;

  // reference state
  logic [31:0] ref_mem [64];
  logic [31:0] ref_rdata = 32'h0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tb_we) mem[tb_idx] <= tb_dat;
    else if (mem_wr) mem[mem_addr[7:2]] <= mem_wdata;
    rd_pipe <= mem[mem_addr[7:2]];
  end
  assign mem_rdata = rd_pipe;

  mem_port_ctrl #(.MEM_LAT(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .wr        (wr),
    .size      (size),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .busy      (busy),
    .done      (done),
    .misalign  (misalign),
    .mem_addr  (mem_addr),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  task automatic preload(input int idx, input logic [31:0] val);
    @(negedge clk);
    tb_we = 1'b1; tb_idx = 6'(idx); tb_dat = val;
    @(negedge clk);
    tb_we = 1'b0;
    ref_mem[idx] = val;
  endtask

  // Issues one request and records what the DUT did, cycle by cycle.
  task automatic run_req(input logic w, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] d,
                         output int done_cyc, output int wr_cyc,
                         output int wr_cnt, output logic [31:0] wr_data,
                         output logic mis, output logic [31:0] rd_at_done,
                         output logic [31:0] addr_c1);
    @(negedge clk);
    req = 1'b1; wr = w; size = sz; addr = a; wdata = d;
    @(posedge clk);
    done_cyc = -1; wr_cyc = -1; wr_cnt = 0; wr_data = 32'h0;
    mis = 1'b0; rd_at_done = 32'h0; addr_c1 = 32'h0;
    for (int k = 1; k <= 20 && done_cyc < 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req = 1'b0; wr = 1'($urandom); size = 2'($urandom);
        addr = $urandom; wdata = $urandom;
        addr_c1 = mem_addr;
      end
      if (mem_wr) begin
        wr_cnt++; wr_cyc = k; wr_data = mem_wdata;
      end
      if (done) begin
        done_cyc = k; mis = misalign; rd_at_done = rdata;
      end
    end
  endtask

  // Computes the expected outcome from the access rules and updates the
  // reference memory/rdata, then compares against what run_req observed.
  task automatic check_req(input string nm, input logic w, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] d);
    int dc, wc, wn;
    logic [31:0] wd, rd, ac;
    logic mi, bad;
    int idx, sh, exp_dc, exp_wc;
    logic [31:0] msk, exp_wd;
    run_req(w, sz, a, d, dc, wc, wn, wd, mi, rd, ac);
    idx = int'(a[7:2]);
    sh  = 8 * int'(a[1:0]);
    msk = (sz == 2'b10) ? 32'hFF : (sz == 2'b01) ? 32'hFFFF : 32'hFFFF_FFFF;
    bad = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b00 && a[1:0] != 2'b00);
    exp_wd = 32'h0;
    exp_wc = -1;
    if (bad) exp_dc = 1;
    else if (w && sz == 2'b00) begin exp_dc = 2; exp_wc = 1; end
    else if (w) begin exp_dc = LAT + 2; exp_wc = LAT + 1; end
    else exp_dc = LAT + 1;
    if (!bad && w) begin
      ref_mem[idx] = (ref_mem[idx] & ~(msk << sh)) | ((d & msk) << sh);
      exp_wd = ref_mem[idx];
    end else if (!bad) begin
      ref_rdata = (ref_mem[idx] >> sh) & msk;
    end

    n_tests++;
    if (dc !== exp_dc) begin
      n_fail++; $display("FAIL %s done_cycle got %0d exp %0d", nm, dc, exp_dc);
    end
    n_tests++;
    if (mi !== bad) begin
      n_fail++; $display("FAIL %s misalign got %0b exp %0b", nm, mi, bad);
    end
    n_tests++;
    if (ac !== {a[31:2], 2'b00}) begin
      n_fail++; $display("FAIL %s mem_addr got %h exp %h", nm, ac, {a[31:2], 2'b00});
    end
    n_tests++;
    if (wn !== ((exp_wc < 0) ? 0 : 1) || wc !== exp_wc) begin
      n_fail++; $display("FAIL %s mem_wr pulses %0d at cycle %0d exp cycle %0d", nm, wn, wc, exp_wc);
    end
    if (exp_wc >= 0) begin
      n_tests++;
      if (wd !== exp_wd) begin
        n_fail++; $display("FAIL %s mem_wdata got %h exp %h", nm, wd, exp_wd);
      end
    end
    n_tests++;
    if (rd !== ref_rdata) begin
      n_fail++; $display("FAIL %s rdata got %h exp %h", nm, rd, ref_rdata);
    end
    n_tests++;
    if (mem[idx] !== ref_mem[idx]) begin
      n_fail++; $display("FAIL %s memory[%0d] got %h exp %h", nm, idx, mem[idx], ref_mem[idx]);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #1;
    n_tests++;
    if ({rdata, mem_addr, mem_wdata} !== 96'h0 || {busy, done, misalign, mem_wr} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset outputs rdata=%h addr=%h wdata=%h busy=%b done=%b mis=%b wr=%b exp all 0",
               rdata, mem_addr, mem_wdata, busy, done, misalign, mem_wr);
    end
    for (int i = 0; i < 64; i++) preload(i, $urandom);
    preload(16, 32'hDEADBEEF);
    @(negedge clk);
    reset = 1'b1;
    ref_rdata = 32'h0;
  endtask

  task automatic test_loads;
    check_req("load_word_40", 1'b0, 2'b00, 32'h40, 32'h0);
    check_req("load_byte_43", 1'b0, 2'b10, 32'h43, 32'h0);
    check_req("load_half_42", 1'b0, 2'b01, 32'h42, 32'h0);
  endtask

  task automatic test_stores;
    check_req("store_byte_41", 1'b1, 2'b10, 32'h41, 32'h0000_0055);
    check_req("store_word_44", 1'b1, 2'b00, 32'h44, 32'h1234_5678);
    check_req("store_half_4a", 1'b1, 2'b01, 32'h4A, 32'hFFFF_ABCD);
  endtask

  task automatic test_misalign;
    check_req("mis_word_42", 1'b1, 2'b00, 32'h42, 32'hAAAA_AAAA);
    check_req("mis_half_41", 1'b0, 2'b01, 32'h41, 32'h0);
    check_req("mis_illegal", 1'b0, 2'b11, 32'h40, 32'h0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      a = $urandom;
      check_req($sformatf("rand_%0d", i), 1'($urandom), 2'($urandom), a, $urandom);
    end
  endtask

  task automatic test_reset_mid_rd;
    int dn;
    preload(16, 32'hDEADBEEF);
    @(negedge clk);
    req = 1'b1; wr = 1'b1; size = 2'b01; addr = 32'h40; wdata = 32'h1234;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    reset = 1'b0;
    #1;
    n_tests++;
    if ({rdata, mem_addr, mem_wdata} !== 96'h0 || {busy, done, misalign, mem_wr} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_mid_rd outputs rdata=%h addr=%h wdata=%h busy=%b done=%b wr=%b exp all 0",
               rdata, mem_addr, mem_wdata, busy, done, mem_wr);
    end
    repeat (4) @(negedge clk);
    reset = 1'b1;
    ref_rdata = 32'h0;
    dn = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) dn++;
    end
    n_tests++;
    if (dn !== 0) begin
      n_fail++; $display("FAIL reset_mid_rd spurious done count %0d exp 0", dn);
    end
    n_tests++;
    if (mem[16] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL reset_mid_rd memory got %h exp deadbeef", mem[16]);
    end
  endtask

  task automatic test_reset_in_wr;
    logic saw_wr;
    @(negedge clk);
    req = 1'b1; wr = 1'b1; size = 2'b00; addr = 32'h44; wdata = 32'hCAFE_F00D;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    saw_wr = mem_wr;
    reset = 1'b0;
    #1;
    n_tests++;
    if (saw_wr !== 1'b1 || mem_wr !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_wr mem_wr before %b after %b exp 1 then 0", saw_wr, mem_wr);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    ref_rdata = 32'h0;
    n_tests++;
    if (mem[17] !== ref_mem[17]) begin
      n_fail++; $display("FAIL reset_in_wr memory got %h exp %h", mem[17], ref_mem[17]);
    end
  endtask

  task automatic test_ignore_req;
    int dn, first;
    preload(16, 32'hDEADBEEF);
    @(negedge clk);
    req = 1'b1; wr = 1'b0; size = 2'b00; addr = 32'h40;
    @(posedge clk);
    dn = 0; first = -1;
    // req stays high, pointing elsewhere, through busy and DONE
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) begin addr = 32'h43; size = 2'b10; end
      if (done) begin
        dn++;
        if (first < 0) first = k;
        req = 1'b1;
      end else if (first >= 0) begin
        req = 1'b0;
      end
    end
    n_tests++;
    if (dn !== 1 || first !== LAT + 1) begin
      n_fail++; $display("FAIL ignore_req done count %0d first %0d exp 1 at %0d", dn, first, LAT + 1);
    end
    n_tests++;
    if (rdata !== 32'hDEADBEEF || busy !== 1'b0) begin
      n_fail++; $display("FAIL ignore_req rdata %h busy %b exp deadbeef 0", rdata, busy);
    end
    ref_rdata = 32'hDEADBEEF;
  endtask

  initial begin
    test_reset;
    test_loads;
    test_stores;
    test_misalign;
    test_reset_mid_rd;
    test_reset_in_wr;
    test_ignore_req;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
